// File: rtl/gnr_attractor_ctrl_if.sv
// Command, node-array and result signals of the GNR attractor sequencer.
// slave: the sequencer itself; master: the host plus the node array.
interface gnr_attractor_ctrl_if #(
    parameter int unsigned N     = 4,
    parameter int unsigned CNT_W = 16
) ();
    logic             start;
    logic             abort;
    logic [N-1:0]     init_base;
    logic [N:0]       sweep_cnt;
    logic [N-1:0]     s0_vec;
    logic [N-1:0]     s1_vec;
    logic             reset_nos;
    logic [N-1:0]     init_state;
    logic             start_s0;
    logic             start_s1;
    logic             busy;
    logic             res_valid;
    logic             res_ready;
    logic [N-1:0]     res_init;
    logic [N-1:0]     res_state;
    logic [CNT_W-1:0] res_meet;
    logic [CNT_W-1:0] res_period;
    logic             res_timeout;
    logic             done;

    modport slave (
        input  start, abort, init_base, sweep_cnt, s0_vec, s1_vec, res_ready,
        output reset_nos, init_state, start_s0, start_s1, busy, res_valid,
               res_init, res_state, res_meet, res_period, res_timeout, done
    );

    modport master (
        output start, abort, init_base, sweep_cnt, s0_vec, s1_vec, res_ready,
        input  reset_nos, init_state, start_s0, start_s1, busy, res_valid,
               res_init, res_state, res_meet, res_period, res_timeout, done
    );
endinterface

// File: rtl/gnr_attractor_ctrl.sv
// Floyd cycle-detection sequencer for a two-stream GNR node array: sweeps initial
// states and reports meet point, attractor period and attractor state per state.
module gnr_attractor_ctrl #(
    parameter int unsigned N        = 4,
    parameter int unsigned CNT_W    = 16,
    parameter int unsigned MAX_ITER = 1000
) (
    input logic                  clk,
    input logic                  rst_n,
    gnr_attractor_ctrl_if.slave  bus
);
    localparam logic [CNT_W-1:0] MaxIter = CNT_W'(MAX_ITER);

    typedef enum logic [2:0] {
        StIdle, StLoad, StRun1, StRun2, StCheck, StPstep, StPcheck, StResult
    } state_e;

    state_e           state_q, state_d;
    logic [N-1:0]     cur_q, cur_d;
    logic [N:0]       rem_q, rem_d;
    logic [CNT_W-1:0] iter_q, iter_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic [CNT_W-1:0] meet_q, meet_d;
    logic [CNT_W-1:0] res_per_q, res_per_d;
    logic [N-1:0]     res_st_q, res_st_d;
    logic             tout_q, tout_d;
    logic             done_q, done_d;
    logic [CNT_W-1:0] iter_inc, period_inc;

    assign iter_inc   = iter_q + 1'b1;
    assign period_inc = period_q + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            cur_q     <= '0;
            rem_q     <= '0;
            iter_q    <= '0;
            period_q  <= '0;
            meet_q    <= '0;
            res_per_q <= '0;
            res_st_q  <= '0;
            tout_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cur_q     <= cur_d;
            rem_q     <= rem_d;
            iter_q    <= iter_d;
            period_q  <= period_d;
            meet_q    <= meet_d;
            res_per_q <= res_per_d;
            res_st_q  <= res_st_d;
            tout_q    <= tout_d;
            done_q    <= done_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cur_d     = cur_q;
        rem_d     = rem_q;
        iter_d    = iter_q;
        period_d  = period_q;
        meet_d    = meet_q;
        res_per_d = res_per_q;
        res_st_d  = res_st_q;
        tout_d    = tout_q;
        done_d    = 1'b0;

        // Abort wins over everything, including a handshake in the same cycle.
        if (bus.abort && state_q != StIdle) begin
            state_d   = StIdle;
            cur_d     = '0;
            rem_d     = '0;
            iter_d    = '0;
            period_d  = '0;
            meet_d    = '0;
            res_per_d = '0;
            res_st_d  = '0;
            tout_d    = 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (bus.start) begin
                        if (bus.sweep_cnt == '0) begin
                            done_d = 1'b1;
                        end else begin
                            cur_d   = bus.init_base;
                            rem_d   = bus.sweep_cnt;
                            state_d = StLoad;
                        end
                    end
                end
                StLoad: begin
                    iter_d    = '0;
                    period_d  = '0;
                    meet_d    = '0;
                    res_per_d = '0;
                    res_st_d  = '0;
                    tout_d    = 1'b0;
                    state_d   = StRun1;
                end
                StRun1: state_d = StRun2;
                StRun2: state_d = StCheck;
                StCheck: begin
                    if (bus.s0_vec == bus.s1_vec) begin
                        meet_d   = iter_inc;
                        res_st_d = bus.s0_vec;
                        state_d  = StPstep;
                    end else if (iter_inc == MaxIter) begin
                        tout_d  = 1'b1;
                        state_d = StResult;
                    end else begin
                        iter_d  = iter_inc;
                        state_d = StRun1;
                    end
                end
                StPstep: state_d = StPcheck;
                StPcheck: begin
                    period_d = period_inc;
                    if (bus.s1_vec == res_st_q) begin
                        res_per_d = period_inc;
                        state_d   = StResult;
                    end else if (period_inc == MaxIter) begin
                        tout_d  = 1'b1;
                        state_d = StResult;
                    end else begin
                        state_d = StPstep;
                    end
                end
                StResult: begin
                    if (bus.res_ready) begin
                        rem_d  = rem_q - 1'b1;
                        cur_d  = cur_q + 1'b1;
                        tout_d = 1'b0;
                        if (rem_q == (N+1)'(1)) begin
                            done_d  = 1'b1;
                            state_d = StIdle;
                        end else begin
                            state_d = StLoad;
                        end
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    // Outputs decode registered state only.
    always_comb begin
        bus.reset_nos   = (state_q == StLoad);
        bus.init_state  = (state_q == StLoad) ? cur_q : '0;
        bus.start_s0    = (state_q == StRun1) || (state_q == StRun2);
        bus.start_s1    = (state_q == StRun1) || (state_q == StRun2) || (state_q == StPstep);
        bus.busy        = (state_q != StIdle);
        bus.res_valid   = (state_q == StResult);
        bus.res_init    = (state_q == StResult) ? cur_q : '0;
        bus.res_state   = res_st_q;
        bus.res_meet    = meet_q;
        bus.res_period  = res_per_q;
        bus.res_timeout = tout_q;
        bus.done        = done_q;
    end
endmodule

// File: tb/tb_gnr_attractor_ctrl.sv
// Directed bench: behavioural two-stream node arrays around two sequencers
// (MAX_ITER 1000 and 8), checked with immediate assertions.
module tb_gnr_attractor_ctrl;
    localparam int unsigned N     = 4;
    localparam int unsigned CNT_W = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int vectors = 0;
    int errors  = 0;
    int nos_cnt = 0;
    int waited;

    gnr_attractor_ctrl_if #(.N(N), .CNT_W(CNT_W)) b1 ();
    gnr_attractor_ctrl_if #(.N(N), .CNT_W(CNT_W)) b2 ();

    gnr_attractor_ctrl #(.N(N), .CNT_W(CNT_W), .MAX_ITER(1000)) dut1 (
        .clk(clk), .rst_n(rst_n), .bus(b1)
    );
    gnr_attractor_ctrl #(.N(N), .CNT_W(CNT_W), .MAX_ITER(8)) dut2 (
        .clk(clk), .rst_n(rst_n), .bus(b2)
    );

    // 0: identity, 1: toggle, 2: 4-bit incrementer
    logic [1:0] mode = 2'd0;

    function automatic logic [N-1:0] nf(input logic [1:0] m, input logic [N-1:0] x);
        case (m)
            2'd0:    nf = x;
            2'd1:    nf = ~x;
            default: nf = x + 1'b1;
        endcase
    endfunction

    logic [N-1:0] a0 = '0, a1 = '0, c0 = '0, c1 = '0;
    logic         ap = 1'b0, cp = 1'b0;

    always @(posedge clk) begin
        if (b1.reset_nos) begin
            a0 <= b1.init_state;
            a1 <= b1.init_state;
            ap <= 1'b1;
        end else begin
            if (b1.start_s0) begin
                ap <= ~ap;
                if (ap) a0 <= nf(mode, a0);
            end
            if (b1.start_s1) a1 <= nf(mode, a1);
        end
        if (b2.reset_nos) begin
            c0 <= b2.init_state;
            c1 <= b2.init_state;
            cp <= 1'b1;
        end else begin
            if (b2.start_s0) begin
                cp <= ~cp;
                if (cp) c0 <= nf(mode, c0);
            end
            if (b2.start_s1) c1 <= nf(mode, c1);
        end
        if (b1.reset_nos) nos_cnt <= nos_cnt + 1;
    end

    assign b1.s0_vec = a0;
    assign b1.s1_vec = a1;
    assign b2.s0_vec = c0;
    assign b2.s1_vec = c1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_busy"}, 32'(b1.busy), 0);
        chk({tag, "_s0"}, 32'(b1.start_s0), 0);
        chk({tag, "_s1"}, 32'(b1.start_s1), 0);
        chk({tag, "_nos"}, 32'(b1.reset_nos), 0);
        chk({tag, "_valid"}, 32'(b1.res_valid), 0);
        chk({tag, "_done"}, 32'(b1.done), 0);
    endtask

    task automatic get1(input string tag, input int ini, input int meet, input int per,
                        input int st, input int tout, output int cyc);
        cyc = 0;
        for (int i = 0; i < 300 && !b1.res_valid; i++) begin
            step();
            cyc++;
        end
        chk({tag, "_valid"}, 32'(b1.res_valid), 1);
        chk({tag, "_init"}, 32'(b1.res_init), 32'(ini));
        chk({tag, "_meet"}, 32'(b1.res_meet), 32'(meet));
        chk({tag, "_period"}, 32'(b1.res_period), 32'(per));
        chk({tag, "_state"}, 32'(b1.res_state), 32'(st));
        chk({tag, "_tout"}, 32'(b1.res_timeout), 32'(tout));
        b1.res_ready = 1'b1;
        step();
        b1.res_ready = 1'b0;
    endtask

    task automatic go(input int base, input int cnt);
        b1.init_base = 4'(base);
        b1.sweep_cnt = 5'(cnt);
        b1.start     = 1'b1;
        step();
        b1.start     = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        b1.start = 0; b1.abort = 0; b1.init_base = 0; b1.sweep_cnt = 0; b1.res_ready = 0;
        b2.start = 0; b2.abort = 0; b2.init_base = 0; b2.sweep_cnt = 0; b2.res_ready = 0;
        #3;
        chk_quiet("reset");
        chk("reset_meet", 32'(b1.res_meet), 0);
        #17 rst_n = 1'b1;
        step();

        // Identity network: fixed point, 7 cycles from LOAD to RESULT
        mode = 2'd0;
        go(5, 1);
        chk("id_load_nos", 32'(b1.reset_nos), 1);
        chk("id_load_init", 32'(b1.init_state), 5);
        chk("id_load_busy", 32'(b1.busy), 1);
        step();
        chk("id_run1_s0", 32'(b1.start_s0), 1);
        chk("id_run1_s1", 32'(b1.start_s1), 1);
        step(); step(); step();
        chk("id_pstep_s0", 32'(b1.start_s0), 0);
        chk("id_pstep_s1", 32'(b1.start_s1), 1);
        get1("id", 5, 1, 1, 5, 0, waited);
        chk("id_latency", 32'(waited), 2);
        chk("id_done", 32'(b1.done), 1);
        chk("id_busy_end", 32'(b1.busy), 0);
        step();
        chk("id_done_once", 32'(b1.done), 0);
        chk("id_nos_count", 32'(nos_cnt), 1);

        // Toggle network, two initial states
        mode = 2'd1;
        go(0, 2);
        get1("tg0", 0, 2, 2, 0, 0, waited);
        get1("tg1", 1, 2, 2, 1, 0, waited);
        chk("tg_done", 32'(b1.done), 1);
        step();

        // Incrementer: full run on dut1, timeout on dut2 (MAX_ITER 8)
        mode = 2'd2;
        b2.init_base = 4'd3;
        b2.sweep_cnt = 5'd1;
        b2.start     = 1'b1;
        go(3, 2);
        b2.start     = 1'b0;
        waited = 0;
        for (int i = 0; i < 300 && !b2.res_valid; i++) begin
            step();
            waited++;
        end
        chk("to_valid", 32'(b2.res_valid), 1);
        chk("to_latency", 32'(waited), 25);
        chk("to_tout", 32'(b2.res_timeout), 1);
        chk("to_meet", 32'(b2.res_meet), 0);
        chk("to_init", 32'(b2.res_init), 3);
        b2.res_ready = 1'b1;
        step();
        b2.res_ready = 1'b0;
        chk("to_done", 32'(b2.done), 1);
        chk("to_busy", 32'(b2.busy), 0);

        for (int i = 0; i < 300 && !b1.res_valid; i++) step();
        for (int i = 0; i < 10; i++) begin
            chk("bp_valid", 32'(b1.res_valid), 1);
            chk("bp_init", 32'(b1.res_init), 3);
            chk("bp_meet", 32'(b1.res_meet), 16);
            chk("bp_period", 32'(b1.res_period), 16);
            chk("bp_state", 32'(b1.res_state), 3);
            chk("bp_idle_nodes", 32'({b1.reset_nos, b1.start_s0, b1.start_s1}), 0);
            step();
        end
        b1.res_ready = 1'b1;
        step();
        b1.res_ready = 1'b0;
        chk("bp_next_load", 32'(b1.reset_nos), 1);
        chk("bp_next_init", 32'(b1.init_state), 4);
        get1("inc4", 4, 16, 16, 4, 0, waited);
        chk("inc_done", 32'(b1.done), 1);
        step();

        // Sweep wrap, with a start pulse while busy
        mode = 2'd0;
        go(15, 3);
        get1("wr15", 15, 1, 1, 15, 0, waited);
        b1.init_base = 4'd7;
        b1.sweep_cnt = 5'd1;
        b1.start     = 1'b1;
        step();
        b1.start     = 1'b0;
        get1("wr0", 0, 1, 1, 0, 0, waited);
        chk("wr_mid_done", 32'(b1.done), 0);
        get1("wr1", 1, 1, 1, 1, 0, waited);
        chk("wr_done", 32'(b1.done), 1);
        step();

        // Empty sweep
        go(2, 0);
        chk("empty_done", 32'(b1.done), 1);
        chk("empty_valid", 32'(b1.res_valid), 0);
        chk("empty_busy", 32'(b1.busy), 0);
        step();
        chk("empty_done_clr", 32'(b1.done), 0);

        // Abort in RUN2
        go(2, 1);
        step(); step();
        chk("ab_run2_s0", 32'(b1.start_s0), 1);
        b1.abort = 1'b1;
        step();
        b1.abort = 1'b0;
        chk_quiet("abort");
        step();
        chk("abort_no_done", 32'(b1.done), 0);

        // Asynchronous reset in PSTEP
        go(9, 1);
        step(); step(); step(); step();
        chk("rs_pstep_s1", 32'(b1.start_s1), 1);
        rst_n = 1'b0;
        #1;
        chk_quiet("rst");
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // Fresh start after reset
        mode = 2'd1;
        go(6, 1);
        get1("fresh", 6, 2, 2, 6, 0, waited);
        chk("fresh_done", 32'(b1.done), 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
